// File: rtl/cordic_pipe_ctrl_if.sv
// Request, datapath and result signals of the CORDIC pipeline controller.
// master: controller side; slave: requesters, datapath and result consumer.
interface cordic_pipe_ctrl_if #(
    parameter int SEQW = 4
);
    logic            flush;

    logic            req0_valid;
    logic            req0_ready;
    logic [15:0]     req0_x;
    logic [15:0]     req0_y;
    logic [15:0]     req0_angle;
    logic [3:0]      req0_sel;

    logic            req1_valid;
    logic            req1_ready;
    logic [15:0]     req1_x;
    logic [15:0]     req1_y;
    logic [15:0]     req1_angle;
    logic [3:0]      req1_sel;

    logic [15:0]     dp_x_init;
    logic [15:0]     dp_y_init;
    logic [15:0]     dp_target_angle;
    logic [3:0]      dp_select;
    logic            dp_reg_en;
    logic [15:0]     dp_x_out;
    logic [15:0]     dp_y_out;
    logic [15:0]     dp_angle_out;

    logic            res_valid;
    logic            res_ready;
    logic [15:0]     res_x;
    logic [15:0]     res_y;
    logic [15:0]     res_angle;
    logic            res_src;
    logic [SEQW-1:0] res_seq;
    logic [2:0]      inflight;

    modport master (
        input  flush,
        input  req0_valid, req0_x, req0_y, req0_angle, req0_sel,
        output req0_ready,
        input  req1_valid, req1_x, req1_y, req1_angle, req1_sel,
        output req1_ready,
        output dp_x_init, dp_y_init, dp_target_angle, dp_select,
        output dp_reg_en,
        input  dp_x_out, dp_y_out, dp_angle_out,
        output res_valid, res_x, res_y, res_angle, res_src, res_seq,
        input  res_ready,
        output inflight
    );

    modport slave (
        output flush,
        output req0_valid, req0_x, req0_y, req0_angle, req0_sel,
        input  req0_ready,
        output req1_valid, req1_x, req1_y, req1_angle, req1_sel,
        input  req1_ready,
        input  dp_x_init, dp_y_init, dp_target_angle, dp_select,
        input  dp_reg_en,
        output dp_x_out, dp_y_out, dp_angle_out,
        input  res_valid, res_x, res_y, res_angle, res_src, res_seq,
        output res_ready,
        input  inflight
    );
endinterface

// File: rtl/cordic_pipe_ctrl.sv
// Issue arbitration and tag tracking for a STAGES-deep CORDIC pipeline.
// Tracking slots shift in lockstep with the datapath registers.
module cordic_pipe_ctrl #(
    parameter int STAGES = 5,
    parameter int SEQW   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    cordic_pipe_ctrl_if.master bus
);

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    logic [STAGES-1:0] src_q;
    logic [STAGES-1:0] src_d;
    logic [SEQW-1:0]   seq_q [STAGES];
    logic [SEQW-1:0]   seq_d [STAGES];
    logic [SEQW-1:0]   seq_cnt_q;
    logic [SEQW-1:0]   seq_cnt_d;
    logic              last_q;
    logic              last_d;

    logic              en;
    logic              gnt0;
    logic              gnt1;
    logic              gnt;
    logic [2:0]        cnt;

    // The pipe stalls only when a finished result is not taken.
    always_comb begin
        en = !(vld_q[STAGES-1] && !bus.res_ready);
    end

    // last_q holds the most recently granted id; 1 after reset so 0 wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n && en && !bus.flush) begin
            if (bus.req0_valid && bus.req1_valid) begin
                gnt0 = last_q;
                gnt1 = !last_q;
            end else begin
                gnt0 = bus.req0_valid;
                gnt1 = bus.req1_valid;
            end
        end
        gnt = gnt0 | gnt1;
    end

    always_comb begin
        bus.dp_x_init       = '0;
        bus.dp_y_init       = '0;
        bus.dp_target_angle = '0;
        bus.dp_select       = '0;
        if (gnt0) begin
            bus.dp_x_init       = bus.req0_x;
            bus.dp_y_init       = bus.req0_y;
            bus.dp_target_angle = bus.req0_angle;
            bus.dp_select       = bus.req0_sel;
        end else if (gnt1) begin
            bus.dp_x_init       = bus.req1_x;
            bus.dp_y_init       = bus.req1_y;
            bus.dp_target_angle = bus.req1_angle;
            bus.dp_select       = bus.req1_sel;
        end
    end

    always_comb begin
        vld_d     = vld_q;
        src_d     = src_q;
        seq_d     = seq_q;
        seq_cnt_d = seq_cnt_q;
        last_d    = last_q;
        if (bus.flush) begin
            vld_d = '0;
        end else if (en) begin
            for (int k = STAGES - 1; k > 0; k--) begin
                vld_d[k] = vld_q[k-1];
                src_d[k] = src_q[k-1];
                seq_d[k] = seq_q[k-1];
            end
            vld_d[0] = gnt;
            src_d[0] = gnt1;
            seq_d[0] = seq_cnt_q;
        end
        if (gnt) begin
            seq_cnt_d = seq_cnt_q + 1'b1;
            last_d    = gnt1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= '0;
            src_q     <= '0;
            seq_cnt_q <= '0;
            last_q    <= 1'b1;
            for (int k = 0; k < STAGES; k++) begin
                seq_q[k] <= '0;
            end
        end else begin
            vld_q     <= vld_d;
            src_q     <= src_d;
            seq_cnt_q <= seq_cnt_d;
            last_q    <= last_d;
            for (int k = 0; k < STAGES; k++) begin
                seq_q[k] <= seq_d[k];
            end
        end
    end

    always_comb begin
        cnt = '0;
        for (int k = 0; k < STAGES; k++) begin
            cnt = cnt + 3'(vld_q[k]);
        end
    end

    assign bus.dp_reg_en  = en;
    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.res_valid  = vld_q[STAGES-1];
    assign bus.res_src    = src_q[STAGES-1];
    assign bus.res_seq    = seq_q[STAGES-1];
    assign bus.res_x      = bus.dp_x_out;
    assign bus.res_y      = bus.dp_y_out;
    assign bus.res_angle  = bus.dp_angle_out;
    assign bus.inflight   = cnt;

endmodule

// File: tb/tb_cordic_pipe_ctrl.sv
// Directed and random checks of cordic_pipe_ctrl against a queue model
// where each in-flight op carries its age in enabled cycles.
module tb_cordic_pipe_ctrl;
    localparam int STAGES = 5;
    localparam int SEQW   = 4;

    typedef struct {
        logic            src;
        logic [SEQW-1:0] seq;
        int              age;
    } op_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cordic_pipe_ctrl_if #(.SEQW(SEQW)) bus ();

    cordic_pipe_ctrl #(
        .STAGES(STAGES),
        .SEQW  (SEQW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    op_t q[$];
    int  m_seq;
    bit  m_last;
    int  errors = 0;
    int  checks = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_seq  = 0;
        m_last = 1'b1;
    endtask

    task automatic drive_req(bit v0, bit v1);
        bus.req0_valid = v0;
        bus.req0_x     = 16'($urandom);
        bus.req0_y     = 16'($urandom);
        bus.req0_angle = 16'($urandom);
        bus.req0_sel   = 4'($urandom);
        bus.req1_valid = v1;
        bus.req1_x     = 16'($urandom);
        bus.req1_y     = 16'($urandom);
        bus.req1_angle = 16'($urandom);
        bus.req1_sel   = 4'($urandom);
    endtask

    // Compare every output with the model; report what the model grants.
    task automatic check_outputs(output bit g0, output bit g1,
                                 output bit ev, output bit een);
        logic [15:0] ex, ey, ea;
        logic [3:0]  es;
        ev  = (q.size() > 0) && (q[0].age == STAGES);
        een = !(ev && !bus.res_ready);
        g0  = 1'b0;
        g1  = 1'b0;
        if (rst_n && een && !bus.flush) begin
            if (bus.req0_valid && bus.req1_valid) begin
                g0 = (m_last == 1'b1);
                g1 = (m_last == 1'b0);
            end else begin
                g0 = bus.req0_valid;
                g1 = bus.req1_valid;
            end
        end
        ex = g0 ? bus.req0_x : g1 ? bus.req1_x : 16'h0;
        ey = g0 ? bus.req0_y : g1 ? bus.req1_y : 16'h0;
        ea = g0 ? bus.req0_angle : g1 ? bus.req1_angle : 16'h0;
        es = g0 ? bus.req0_sel : g1 ? bus.req1_sel : 4'h0;
        chk("dp_reg_en", 32'(bus.dp_reg_en), 32'(een));
        chk("req0_ready", 32'(bus.req0_ready), 32'(g0));
        chk("req1_ready", 32'(bus.req1_ready), 32'(g1));
        chk("res_valid", 32'(bus.res_valid), 32'(ev));
        chk("inflight", 32'(bus.inflight), 32'(q.size()));
        chk("dp_x_init", 32'(bus.dp_x_init), 32'(ex));
        chk("dp_y_init", 32'(bus.dp_y_init), 32'(ey));
        chk("dp_angle", 32'(bus.dp_target_angle), 32'(ea));
        chk("dp_select", 32'(bus.dp_select), 32'(es));
        chk("res_x", 32'(bus.res_x), 32'(bus.dp_x_out));
        chk("res_y", 32'(bus.res_y), 32'(bus.dp_y_out));
        chk("res_angle", 32'(bus.res_angle), 32'(bus.dp_angle_out));
        if (ev) begin
            chk("res_src", 32'(bus.res_src), 32'(q[0].src));
            chk("res_seq", 32'(bus.res_seq), 32'(q[0].seq));
        end
    endtask

    // Entered at posedge+1; checks at posedge+4, returns at next posedge+1.
    task automatic cycle();
        bit g0, g1, ev, een;
        op_t op;
        bus.dp_x_out     = 16'($urandom);
        bus.dp_y_out     = 16'($urandom);
        bus.dp_angle_out = 16'($urandom);
        #3;
        check_outputs(g0, g1, ev, een);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (bus.flush) begin
            q.delete();
        end else if (een) begin
            if (ev && bus.res_ready) void'(q.pop_front());
            foreach (q[i]) q[i].age++;
            if (g0 || g1) begin
                op.src = g1;
                op.seq = SEQW'(m_seq);
                op.age = 1;
                q.push_back(op);
                m_seq  = (m_seq + 1) % (1 << SEQW);
                m_last = g1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_req(1'b1, 1'b1);
        cycle();
        cycle();
        rst_n = 1'b1;
        drive_req(1'b0, 1'b0);
    endtask

    initial begin
        bit g0, g1, ev, een;
        int first_valid;
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.res_ready = 1'b1;
        drive_req(1'b0, 1'b0);
        model_reset();
        @(posedge clk);
        #1;

        // Reset state with both requesters asking.
        do_reset();

        // Single issue from requester 0 with known operands.
        drive_req(1'b1, 1'b0);
        bus.req0_x     = 16'h4000;
        bus.req0_y     = 16'h0000;
        bus.req0_angle = 16'h2D00;
        bus.req0_sel   = 4'h1;
        cycle();
        drive_req(1'b0, 1'b0);
        first_valid = -1;
        for (int i = 1; i <= 8; i++) begin
            if (bus.res_valid === 1'b1 && first_valid < 0) first_valid = i;
            cycle();
        end
        chk("single_latency", 32'(first_valid), 32'd5);

        // Contention: both valid for 4 cycles.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_req(1'b1, 1'b1);
            cycle();
        end
        drive_req(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle();

        // Back-to-back issues with a 3-cycle backpressure window.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive_req(i < 8, 1'b0);
            bus.res_ready = !(i >= 5 && i < 8);
            if (i == 6) chk("bp_inflight", 32'(bus.inflight), 32'd5);
            cycle();
        end
        bus.res_ready = 1'b1;

        // Sequence tag wrap from requester 1.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive_req(1'b0, 1'b1);
            cycle();
        end
        drive_req(1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cycle();

        // Flush with 3 in flight and requester 0 asking.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_req(1'b1, 1'b0);
            cycle();
        end
        drive_req(1'b1, 1'b0);
        bus.flush = 1'b1;
        cycle();
        bus.flush = 1'b0;
        drive_req(1'b0, 1'b0);
        chk("flush_inflight", 32'(bus.inflight), 32'd0);
        for (int i = 0; i < 7; i++) cycle();

        // Asynchronous reset while 4 ops sit in a stalled pipe.
        do_reset();
        bus.res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_req(1'b1, 1'b0);
            cycle();
        end
        drive_req(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle();
        chk("stall_en", 32'(bus.dp_reg_en), 32'd0);
        drive_req(1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs(g0, g1, ev, een);
        cycle();
        rst_n = 1'b1;
        bus.res_ready = 1'b1;
        cycle();
        drive_req(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle();

        // Random traffic, backpressure and occasional flush.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive_req($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
            bus.res_ready = $urandom_range(0, 3) != 0;
            bus.flush     = $urandom_range(0, 29) == 0;
            cycle();
        end
        bus.flush     = 1'b0;
        bus.res_ready = 1'b1;
        drive_req(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cordic_pipe_ctrl.md
CORDIC_PIPE_CTRL -- requirements
Module: cordic_pipe_ctrl

Interface
REQ-001 SHALL have parameter STAGES, default 5, meaning number of clocked register stages in the controlled CORDIC pipeline.
REQ-002 SHALL have parameter SEQW, default 4, meaning width of the issue sequence tag.
REQ-003 SHALL provide these ports: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline invalidate.
- reqN_valid  in  1  requester N (N=0,1) has an operation.
- reqN_ready  out  1  requester N operation accepted this cycle.
- reqN_x, reqN_y, reqN_angle  in  16 each  requester N operands.
- reqN_sel  in  4  requester N mode select.
- dp_x_init, dp_y_init, dp_target_angle  out  16 each  datapath operands.
- dp_select  out  4  datapath mode.
- dp_reg_en  out  1  datapath stage register enable.
- dp_x_out, dp_y_out, dp_angle_out  in  16 each  datapath results.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_x, res_y, res_angle  out  16 each  result, forwarded from dp_*_out.
- res_src  out  1  requester id of the result.
- res_seq  out  SEQW  issue tag of the result.
- inflight  out  3  count of valid pipeline slots.

Function
REQ-004 SHALL keep a STAGES-deep tracking shift register holding {valid, src, seq} per slot; slot k mirrors datapath register k+1.
REQ-005 SHALL drive dp_reg_en = NOT(slot[STAGES-1].valid AND NOT res_ready), combinationally.
REQ-006 SHALL advance the tracking register only on cycles with dp_reg_en=1, in lockstep with the datapath; when dp_reg_en=0, all slots SHALL hold.
REQ-007 SHALL drive res_valid = slot[STAGES-1].valid; res_src and res_seq from that slot; res_x/y/angle = dp_x_out/dp_y_out/dp_angle_out.
REQ-008 SHALL define a result transfer as res_valid AND res_ready on a rising edge.
REQ-009 SHALL grant at most one requester per cycle, and only when dp_reg_en=1 and flush=0.
REQ-010 SHALL arbitrate round-robin: with both valid, grant the requester not granted most recently; with one valid, grant it.
REQ-011 SHALL assert reqN_ready combinationally in the granted cycle only, never while reqN_valid=0.
REQ-012 SHALL mux the granted requester's operands onto dp_x_init, dp_y_init, dp_target_angle and dp_select; with no grant these outputs SHALL be 0.
REQ-013 SHALL load slot 0 with {1, granted id, seq_cnt} on a grant edge, else with valid=0 when advancing.
REQ-014 SHALL increment seq_cnt, modulo 2^SEQW (15 wraps to 0), on each grant.
REQ-015 SHALL give result latency of exactly STAGES enabled cycles from grant edge to res_valid; 5 cycles when unstalled.
REQ-016 SHALL clear all slot valid bits on flush=1, with no grant that cycle; seq_cnt and the round-robin pointer are unchanged. Flush overrides a simultaneous result transfer.
REQ-017 SHALL drive inflight as the popcount of slot valid bits, 0..STAGES, registered state only.
REQ-018 SHALL accept a new issue in the same cycle as a result transfer, giving full throughput of one op per cycle.
REQ-019 SHALL NOT require requester operands to remain stable after the grant edge.

Reset
REQ-020 SHALL on rst_n=0, asynchronously: clear all slot valid bits to 0, clear src/seq fields to 0, set seq_cnt=0, and set the round-robin pointer so requester 0 wins the first contention.
REQ-021 SHALL hold these output values during reset: res_valid=0, inflight=0, reqN_ready=0, dp_reg_en=1, dp_* operands=0.
REQ-022 SHALL, on reset mid-operation, discard all in-flight results; no res_valid until a fresh issue completes.

Verification
REQ-023 Single issue: req0 x=0x4000 y=0 angle=0x2D00 sel=1, res_ready=1 -> res_valid exactly 5 cycles later, res_src=0, res_seq=0, inflight peaks at 1.
REQ-024 Contention: both valid for 4 cycles after reset -> grants alternate 0,1,0,1; res_seq 0..3 return in order with matching res_src.
REQ-025 Backpressure: 5 back-to-back issues, res_ready=0 at first res_valid for 3 cycles -> dp_reg_en=0 for 3 cycles, reqN_ready=0, no result lost or duplicated, inflight=5.
REQ-026 Seq wrap: 17 issues from requester 1 -> res_seq sequence 0..15,0.
REQ-027 Flush with 3 in flight and req0 valid -> req0_ready=0 that cycle, inflight=0 next cycle, no res_valid for flushed ops.
REQ-028 Async reset asserted with 4 in flight mid-stall -> res_valid=0 and inflight=0 immediately, dp_reg_en=1, next issue gets res_seq=0.
